// File: rtl/arith_pkg.sv
// Shared arithmetic-library types: serial FSM state encoding and operation-mode encoding.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          MODE_W   = 1;
    localparam logic [MODE_W-1:0] MODE_SUB = 1'b0;
    localparam logic [MODE_W-1:0] MODE_ADD = 1'b1;

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit combinational full-subtractor (a - b - bin). With SERIAL_SUBTRACTOR_ADD_MODE_EN
// the extra add input turns it into a full adder whose bout is the carry-out.
module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic add,
`endif
    output logic d,
    output logic bout
);

    logic a_eff;

    // Inverting the minuend bit in the borrow term yields the adder carry equation.
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    assign a_eff = a ^ add;
`else
    assign a_eff = a;
`endif

    assign d    = a ^ b ^ bin;
    assign bout = (~a_eff & b) | (~(a_eff ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Optional SERIAL_SUBTRACTOR_ADD_MODE_EN adds a mode input selecting addition.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic             mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_sh_reg, b_sh_reg, diff_reg;
    logic [CW-1:0]     cnt_reg;
    logic              bin_reg;
    logic              a_msb_reg, b_msb_reg;
    logic              cell_d, cell_bout;
    logic              last_bit;
    logic              is_done;
    logic              ovf_raw;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic [MODE_W-1:0] mode_reg;
`endif

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));
    assign is_done  = (state_reg == DONE);

    serial_sub_cell u_cell (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (bin_reg),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        .add  (mode_reg == MODE_ADD),
`endif
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            diff_reg  <= '0;
            cnt_reg   <= '0;
            bin_reg   <= 1'b0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
            mode_reg  <= MODE_SUB;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        cnt_reg   <= '0;
                        bin_reg   <= 1'b0;
                        a_msb_reg <= a[WIDTH-1];
                        b_msb_reg <= b[WIDTH-1];
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
                        mode_reg  <= mode;
`endif
                    end
                end
                RUN: begin
                    // Result fills from the top so the LSB lands at bit 0 after WIDTH shifts.
                    diff_reg <= {cell_d, diff_reg[WIDTH-1:1]};
                    a_sh_reg <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    bin_reg  <= cell_bout;
                    cnt_reg  <= cnt_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    assign ovf_raw = (mode_reg == MODE_ADD)
                   ? ((a_msb_reg == b_msb_reg) && (diff_reg[WIDTH-1] != a_msb_reg))
                   : ((a_msb_reg != b_msb_reg) && (diff_reg[WIDTH-1] != a_msb_reg));
`else
    assign ovf_raw = (a_msb_reg != b_msb_reg) && (diff_reg[WIDTH-1] != a_msb_reg);
`endif

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = is_done;
    assign diff      = diff_reg;
    assign borrow    = is_done & bin_reg;
    assign overflow  = is_done & ovf_raw;
    assign zero      = is_done & (diff_reg == '0);

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor: accepts two WIDTH-bit operands through a valid/ready handshake and computes A − B one bit per clock, LSB first, through a single one-bit full-subtractor cell with a registered borrow. It trades WIDTH cycles of latency for one-bit datapath logic. It sits beside the ripple-carry adder cells in the arithmetic library as the serial, inverse-direction counterpart for area-constrained paths.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..32.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands a and b are presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result fields valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a − b) mod 2^WIDTH.
- borrow  output  1  unsigned a < b.
- overflow  output  1  signed overflow: sign(a) ≠ sign(b) and sign(diff) ≠ sign(a).
- zero  output  1  diff == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid & in_ready: load a and b into shift registers, clear the bit counter, set the borrow flop to 0, capture the operand MSBs for the overflow check, go to RUN.
- RUN: each cycle, the cell computes d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin). d shifts into the MSB of the result register, both operand registers shift right, and the borrow flop takes bout. After the WIDTH-th bit, go to DONE.
- DONE: out_valid=1. borrow is the final borrow flop value. overflow and zero derive from registered values only. Outputs hold steady until out_ready=1, then go to IDLE.
- in_valid outside IDLE is ignored. Operands are not re-sampled.
- out_ready outside DONE is ignored.
- Reset, at any state including mid-RUN: state=IDLE, in_ready=1 on the following cycle, out_valid=0, diff=0, borrow=0, overflow=0, zero=0. Any in-flight operation is discarded.
- Bit counter width is $clog2(WIDTH+1). The counter does not wrap within one operation.

## Timing
- Acceptance edge k: the handshake is sampled at edge k. RUN occupies edges k+1..k+WIDTH. out_valid rises after edge k+WIDTH.
- Result latency is WIDTH cycles from acceptance to out_valid. Throughput is at most one operation per WIDTH+2 cycles, because IDLE always lasts at least one cycle after DONE.
- The DONE→IDLE transition occurs on the edge where out_valid & out_ready are both high. in_ready rises on the following cycle. There is no same-cycle pass-through from output to input.
- All outputs are registered or decoded from registered state. There are no combinational paths from input to output.

## Configuration
- SERIAL_SUBTRACTOR_ADD_MODE_EN defined:
  - Adds input port `mode` (1 bit), sampled with the operands at acceptance. mode=1 selects addition: b is used uninverted, the cell acts as a full adder, and `borrow` reports the unsigned carry-out.
  - In add mode, overflow is signed add overflow: sign(a) == sign(b) and sign(diff) ≠ sign(a).
  - mode=0 behaves exactly as subtraction.
- Macro not defined: no `mode` port. Subtraction only.

## Structure
- Shared package `arith_pkg`:
  - State enum type for IDLE, RUN, DONE.
  - Widths for the mode encoding.
- Sub-module `serial_sub_cell`: a one-bit combinational full-subtractor (a, b, bin → d, bout).
  - With SERIAL_SUBTRACTOR_ADD_MODE_EN defined, it takes an extra `add` input that inverts the borrow sense.
- Top level owns the FSM, the shift registers, the bit counter, the borrow flop and the flag logic.

## Test plan
- WIDTH=8, a=0x05, b=0x03, out_ready=1 → out_valid after edge k+8; diff=0x02, borrow=0, overflow=0, zero=0.
- a=0x03, b=0x05 → diff=0xFE, borrow=1, overflow=0. Then a=0x80, b=0x01 → diff=0x7F, borrow=0, overflow=1.
- a=0x5A, b=0x5A → diff=0x00, zero=1, borrow=0. Then a=0x00, b=0x00 → diff=0x00, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and all outputs constant, in_ready=0, and new in_valid is ignored. Raise out_ready → IDLE on the next edge.
- Reset mid-RUN: assert rst_n=0 at RUN bit 4 → next cycle state=IDLE, in_ready=1, all outputs 0. A new operation a=0x10, b=0x01 then yields diff=0x0F.
- Add mode (macro defined): mode=1, a=0xFF, b=0x01 → diff=0x00, borrow (carry)=1, overflow=0, zero=1.
